// File: rtl/alu_exec_core.sv
// alu_exec_core: start/done handshake execution unit with add/logic/mul/div,
// a small scratch memory, and a last-result register for operand chaining.
module alu_exec_core #(
  parameter int unsigned MEM_DEPTH  = 16,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        sv,
  input  logic        op_prefix,
  output logic        done,
  output logic [63:0] result,
  output logic [7:0]  err,
  output logic        gp
);

  localparam int unsigned AddrW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // The divider always performs 32 restoring steps; DIV_CYCLES must be >= 32.
  localparam int unsigned DivSteps = 32;
  localparam int unsigned CntW     = $clog2(DIV_CYCLES + MUL_CYCLES + DivSteps + 4);

  localparam logic [7:0] OpNop = 8'd0;
  localparam logic [7:0] OpAdd = 8'd1;
  localparam logic [7:0] OpAnd = 8'd2;
  localparam logic [7:0] OpXor = 8'd3;
  localparam logic [7:0] OpMul = 8'd4;
  localparam logic [7:0] OpDiv = 8'd5;
  localparam logic [7:0] OpLda = 8'd6;
  localparam logic [7:0] OpSta = 8'd7;
  localparam logic [7:0] OpMov = 8'd8;
  localparam logic [7:0] OpSwp = 8'd9;
  localparam logic [7:0] OpWmr = 8'd10;

  localparam logic [7:0] ErrOk      = 8'd0;
  localparam logic [7:0] ErrDivZero = 8'd1;
  localparam logic [7:0] ErrIllegal = 8'd2;
  localparam logic [7:0] ErrAddr    = 8'd3;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [7:0]          op_q, op_d;
  logic [31:0]         a_q, a_d;
  logic [31:0]         b_q, b_d;
  logic                sv_q, sv_d;
  logic [31:0]         last_q, last_d;
  logic [31:0]         mem_q [MEM_DEPTH];
  logic [31:0]         mem_d [MEM_DEPTH];
  logic [31:0]         div_rem_q, div_rem_d;
  logic [31:0]         div_quo_q, div_quo_d;
  logic [31:0]         div_dvs_q, div_dvs_d;
  logic                div_qneg_q, div_qneg_d;
  logic                div_rneg_q, div_rneg_d;
  logic [63:0]         result_q, result_d;
  logic [7:0]          err_q, err_d;
  logic                gp_q, gp_d;

  // Execution datapath signals derived from the latched operation
  logic [AddrW-1:0]    a_idx, b_idx;
  logic                a_oob, b_oob;
  logic [31:0]         rd_a, rd_b;
  logic [32:0]         sum33;
  logic [63:0]         prod;
  logic [31:0]         quo_fin, rem_fin;
  logic [63:0]         res_c;
  logic [7:0]          err_c;
  logic                gp_c;
  logic [CntW-1:0]     lat;
  logic                wr_a_en, wr_b_en;
  logic [31:0]         wr_a_data, wr_b_data;
  logic [31:0]         b_eff;
  logic [32:0]         div_shift;
  logic [32:0]         div_diff;

  // Combinational result, error, latency and memory-write decode for the current op
  always_comb begin
    a_idx     = a_q[AddrW-1:0];
    b_idx     = b_q[AddrW-1:0];
    a_oob     = (a_q >= 32'(MEM_DEPTH));
    b_oob     = (b_q >= 32'(MEM_DEPTH));
    rd_a      = mem_q[a_idx];
    rd_b      = mem_q[b_idx];
    sum33     = sv_q ? ({a_q[31], a_q} + {b_q[31], b_q}) : ({1'b0, a_q} + {1'b0, b_q});
    prod      = sv_q ? 64'($signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q}))
                     : ({32'd0, a_q} * {32'd0, b_q});
    quo_fin   = div_qneg_q ? (32'd0 - div_quo_q) : div_quo_q;
    rem_fin   = div_rneg_q ? (32'd0 - div_rem_q) : div_rem_q;
    res_c     = '0;
    err_c     = ErrOk;
    lat       = CntW'(1);
    wr_a_en   = 1'b0;
    wr_b_en   = 1'b0;
    wr_a_data = '0;
    wr_b_data = '0;
    unique case (op_q)
      OpNop: res_c = '0;
      OpAdd: res_c = sv_q ? {{31{sum33[32]}}, sum33} : {31'd0, sum33};
      OpAnd: res_c = {32'd0, a_q & b_q};
      OpXor: res_c = {32'd0, a_q ^ b_q};
      OpMul: begin
        res_c = prod;
        lat   = CntW'(MUL_CYCLES);
      end
      OpDiv: begin
        if (b_q == 32'd0) begin
          err_c = ErrDivZero;
        end else begin
          res_c = {rem_fin, quo_fin};
          lat   = CntW'(DIV_CYCLES);
        end
      end
      OpLda: begin
        if (a_oob) err_c = ErrAddr;
        else res_c = sv_q ? {{32{rd_a[31]}}, rd_a} : {32'd0, rd_a};
      end
      OpSta: begin
        if (a_oob) begin
          err_c = ErrAddr;
        end else begin
          wr_a_en   = 1'b1;
          wr_a_data = b_q;
          res_c     = {32'd0, b_q};
        end
      end
      OpMov: begin
        if (a_oob || b_oob) begin
          err_c = ErrAddr;
        end else begin
          wr_b_en   = 1'b1;
          wr_b_data = rd_a;
          res_c     = {32'd0, rd_a};
        end
      end
      OpSwp: begin
        if (a_oob || b_oob) begin
          err_c = ErrAddr;
        end else begin
          wr_a_en   = 1'b1;
          wr_a_data = rd_b;
          wr_b_en   = 1'b1;
          wr_b_data = rd_a;
          res_c     = {rd_a, rd_b};
          lat       = CntW'(2);
        end
      end
      OpWmr: begin
        if (a_oob) begin
          err_c = ErrAddr;
        end else begin
          wr_a_en   = 1'b1;
          wr_a_data = last_q;
          res_c     = {32'd0, last_q};
        end
      end
      default: err_c = ErrIllegal;
    endcase
    gp_c = (err_c == ErrOk) && (sv_q ? ($signed(res_c) > 64'sd0) : (res_c != 64'd0));
  end

  // Handshake FSM, operand latch, divider stepping and DONE-entry commit
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    sv_d       = sv_q;
    last_d     = last_q;
    mem_d      = mem_q;
    div_rem_d  = div_rem_q;
    div_quo_d  = div_quo_q;
    div_dvs_d  = div_dvs_q;
    div_qneg_d = div_qneg_q;
    div_rneg_d = div_rneg_q;
    result_d   = result_q;
    err_d      = err_q;
    gp_d       = gp_q;
    b_eff      = op_prefix ? last_q : B;
    div_shift  = {div_rem_q, div_quo_q[31]};
    div_diff   = div_shift - {1'b0, div_dvs_q};
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d       = op;
          a_d        = A;
          b_d        = b_eff;
          sv_d       = sv;
          cnt_d      = '0;
          // Divider works on magnitudes; signs are reapplied at the end
          div_rem_d  = '0;
          div_quo_d  = (sv && A[31]) ? (32'd0 - A) : A;
          div_dvs_d  = (sv && b_eff[31]) ? (32'd0 - b_eff) : b_eff;
          div_qneg_d = sv && (A[31] ^ b_eff[31]);
          div_rneg_d = sv && A[31];
          state_d    = StExec;
        end
      end
      StExec: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q < CntW'(DivSteps)) begin
          if (!div_diff[32]) begin
            div_rem_d = div_diff[31:0];
            div_quo_d = {div_quo_q[30:0], 1'b1};
          end else begin
            div_rem_d = div_shift[31:0];
            div_quo_d = {div_quo_q[30:0], 1'b0};
          end
        end
        if (cnt_q == lat) begin
          state_d  = StDone;
          result_d = res_c;
          err_d    = err_c;
          gp_d     = gp_c;
          if (err_c == ErrOk) begin
            last_d = res_c[31:0];
            if (wr_a_en) mem_d[a_idx] = wr_a_data;
            if (wr_b_en) mem_d[b_idx] = wr_b_data;
          end
        end
      end
      StDone: begin
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sv_q       <= 1'b0;
      last_q     <= '0;
      mem_q      <= '{default: '0};
      div_rem_q  <= '0;
      div_quo_q  <= '0;
      div_dvs_q  <= '0;
      div_qneg_q <= 1'b0;
      div_rneg_q <= 1'b0;
      result_q   <= '0;
      err_q      <= '0;
      gp_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sv_q       <= sv_d;
      last_q     <= last_d;
      mem_q      <= mem_d;
      div_rem_q  <= div_rem_d;
      div_quo_q  <= div_quo_d;
      div_dvs_q  <= div_dvs_d;
      div_qneg_q <= div_qneg_d;
      div_rneg_q <= div_rneg_d;
      result_q   <= result_d;
      err_q      <= err_d;
      gp_q       <= gp_d;
    end
  end

  assign done   = (state_q == StDone);
  assign result = result_q;
  assign err    = err_q;
  assign gp     = gp_q;

endmodule

// File: tb/tb_alu_exec_core.sv
// Scoreboard bench for alu_exec_core: the driver queues expected responses,
// a monitor pops and compares each time done rises.
module tb_alu_exec_core;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        sv;
  logic        op_prefix;
  logic        done;
  logic [63:0] result;
  logic [7:0]  err;
  logic        gp;

  alu_exec_core #(
    .MEM_DEPTH (16),
    .DIV_CYCLES(32),
    .MUL_CYCLES(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .A        (a),
    .B        (b),
    .sv       (sv),
    .op_prefix(op_prefix),
    .done     (done),
    .result   (result),
    .err      (err),
    .gp       (gp)
  );

  typedef struct {
    string       name;
    logic [63:0] res;
    logic [7:0]  err;
    logic        gp;
    int          issue;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic done_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  // Monitor: compare DUT response against the oldest queued expectation
  always @(negedge clk) begin
    if (!reset && done && !done_prev) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no response pending");
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, "/result"}, result, mon_e.res);
        check({mon_e.name, "/err"}, 64'(err), 64'(mon_e.err));
        check({mon_e.name, "/gp"}, 64'(gp), 64'(mon_e.gp));
        check({mon_e.name, "/latency"}, 64'(cyc - mon_e.issue), 64'(mon_e.lat));
      end
    end
    done_prev = done;
  end

  task automatic run_op(input string name, input logic [7:0] o, input logic [31:0] opa,
                        input logic [31:0] opb, input logic s, input logic pfx,
                        input logic [63:0] er, input logic [7:0] ee, input logic eg,
                        input int elat, input int hold);
    exp_t e;
    int   n;
    @(negedge clk);
    op        = o;
    a         = opa;
    b         = opb;
    sv        = s;
    op_prefix = pfx;
    start     = 1'b1;
    @(posedge clk);
    #1;
    e.name  = name;
    e.res   = er;
    e.err   = ee;
    e.gp    = eg;
    e.issue = cyc;
    e.lat   = elat;
    sb_q.push_back(e);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s/timeout: got done=0 after %0d cycles, expected done=1", name, n);
      if (sb_q.size() > 0) void'(sb_q.pop_back());
      start = 1'b0;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "/done_hold"}, 64'(done), 64'd1);
    end
    start = 1'b0;
    @(negedge clk);
    check({name, "/done_drop"}, 64'(done), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    op        = '0;
    a         = '0;
    b         = '0;
    sv        = 1'b0;
    op_prefix = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/done", 64'(done), 64'd0);
    check("reset/result", result, 64'd0);
    check("reset/err", 64'(err), 64'd0);
    check("reset/gp", 64'(gp), 64'd0);
    reset = 1'b0;

    // Arithmetic and logic
    run_op("add_signed", 8'd1, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0, 64'd4, 8'd0, 1'b1, 2, 3);
    run_op("add_unsigned", 8'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0,
           64'h0000_0001_0000_0000, 8'd0, 1'b1, 2, 0);
    run_op("mul_unsigned", 8'd4, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0,
           64'h0000_0001_FFFF_FFFE, 8'd0, 1'b1, 4, 0);
    run_op("mul_signed", 8'd4, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFE, 8'd0, 1'b0, 4, 0);
    run_op("div_signed", 8'd5, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFD, 8'd0, 1'b0, 33, 0);
    run_op("div_zero", 8'd5, 32'd7, 32'd0, 1'b1, 1'b0, 64'd0, 8'd1, 1'b0, 2, 0);
    run_op("div_unsigned", 8'd5, 32'd100, 32'd7, 1'b0, 1'b0,
           64'h0000_0002_0000_000E, 8'd0, 1'b1, 33, 0);
    run_op("div_minint", 8'd5, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0,
           64'h0000_0000_8000_0000, 8'd0, 1'b1, 33, 0);
    run_op("and", 8'd2, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 1'b0, 64'h0000_F000, 8'd0, 1'b1,
           2, 0);
    run_op("xor", 8'd3, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b1, 1'b0,
           64'h0000_0000_F0F0_F0F0, 8'd0, 1'b1, 2, 0);
    run_op("nop", 8'd0, 32'd5, 32'd6, 1'b0, 1'b0, 64'd0, 8'd0, 1'b0, 2, 0);

    // Scratch memory
    run_op("sta3", 8'd7, 32'd3, 32'h55, 1'b0, 1'b0, 64'h55, 8'd0, 1'b1, 2, 0);
    run_op("mov3to5", 8'd8, 32'd3, 32'd5, 1'b0, 1'b0, 64'h55, 8'd0, 1'b1, 2, 0);
    run_op("swp3_9", 8'd9, 32'd3, 32'd9, 1'b0, 1'b0, 64'h0000_0055_0000_0000, 8'd0, 1'b1,
           3, 0);
    run_op("lda9", 8'd6, 32'd9, 32'd0, 1'b0, 1'b0, 64'h55, 8'd0, 1'b1, 2, 0);
    run_op("lda3", 8'd6, 32'd3, 32'd0, 1'b0, 1'b0, 64'd0, 8'd0, 1'b0, 2, 0);
    run_op("lda5", 8'd6, 32'd5, 32'd0, 1'b0, 1'b0, 64'h55, 8'd0, 1'b1, 2, 0);
    run_op("lda16", 8'd6, 32'd16, 32'd0, 1'b0, 1'b0, 64'd0, 8'd3, 1'b0, 2, 0);
    run_op("wmr7", 8'd10, 32'd7, 32'd0, 1'b0, 1'b0, 64'h55, 8'd0, 1'b1, 2, 0);
    run_op("lda7", 8'd6, 32'd7, 32'd0, 1'b0, 1'b0, 64'h55, 8'd0, 1'b1, 2, 0);

    // Prefix chain and illegal opcode
    run_op("chain_add", 8'd1, 32'd1, 32'd2, 1'b0, 1'b0, 64'd3, 8'd0, 1'b1, 2, 0);
    run_op("chain_pfx", 8'd1, 32'd10, 32'h0000_DEAD, 1'b0, 1'b1, 64'd13, 8'd0, 1'b1, 2, 0);
    run_op("illegal", 8'd11, 32'd1, 32'd1, 1'b1, 1'b0, 64'd0, 8'd2, 1'b0, 2, 0);
    run_op("chain_keep", 8'd1, 32'd0, 32'h0000_BEEF, 1'b0, 1'b1, 64'd13, 8'd0, 1'b1, 2, 0);

    // Reset in the middle of a divide
    @(negedge clk);
    op        = 8'd5;
    a         = 32'd100;
    b         = 32'd7;
    sv        = 1'b0;
    op_prefix = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("midreset/done", 64'(done), 64'd0);
    check("midreset/result", result, 64'd0);
    check("midreset/err", 64'(err), 64'd0);
    check("midreset/gp", 64'(gp), 64'd0);
    reset = 1'b0;

    run_op("post_pfx", 8'd1, 32'd5, 32'd99, 1'b0, 1'b1, 64'd5, 8'd0, 1'b1, 2, 0);
    run_op("post_lda9", 8'd6, 32'd9, 32'd0, 1'b0, 1'b0, 64'd0, 8'd0, 1'b0, 2, 0);
    run_op("post_lda7", 8'd6, 32'd7, 32'd0, 1'b0, 1'b0, 64'd0, 8'd0, 1'b0, 2, 0);
    run_op("post_add", 8'd1, 32'd7, 32'd8, 1'b1, 1'b0, 64'd15, 8'd0, 1'b1, 2, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
